rr_arbiter4: RTL
================

Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter sharing one resource among requesters 0..3.
- Winner is held as a 2-bit index. The one-hot grant vector is the 2-to-4 decode of that index: index 00 -> gnt[0], 11 -> gnt[3].
- Grant lasts until the owner signals done, drops its request, or a hold timeout fires.
- Sits in front of any shared datapath unit; the one-hot grant is its select/enable.

Parameters:
- MAX_HOLD, 15: maximum cycles a grant is held before forced release; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the hold counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  [0:3]  request lines; req[i] is requester i.
- done  input  1  owner finished; sampled only while busy=1.
- gnt  output  [0:3]  one-hot grant; decode of gnt_idx when busy=1, else 0000.
- gnt_idx  output  [0:1]  index of current owner; 00 when idle.
- busy  output  1  a grant is active.
- timeout  output  1  one-cycle pulse, registered, on forced release.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-grant):
  - gnt=0000, gnt_idx=00, busy=0, timeout=0.
  - State=IDLE, hold_cnt=0, last_idx=11, so requester 0 has top priority after reset.
- States: IDLE, GRANT. All outputs are registered.
- IDLE:
  - If any req bit is 1: pick the first requester set in the order last_idx+1, last_idx+2, last_idx+3, last_idx (mod 4, wrap 3->0).
  - Next cycle: state=GRANT, gnt_idx=winner, gnt=decode(winner), busy=1, hold_cnt=1.
  - Latency: req sampled high -> gnt high one cycle later.
  - If no req: stay IDLE, outputs stay 0.
- GRANT, evaluated at each clock edge:
  - Release when done=1, or req[gnt_idx]=0, or hold_cnt==MAX_HOLD.
  - Otherwise hold_cnt increments and the grant holds.
  - On release: next cycle state=IDLE, gnt=0000, busy=0, gnt_idx=00, last_idx=released owner, hold_cnt=0.
  - timeout=1 for that one cycle only if release was caused solely by hold_cnt==MAX_HOLD, with done=0 and the owner's req still high. done or req-drop in the same cycle as the limit means no timeout.
- Minimum one IDLE cycle between consecutive grants; back-to-back grants are spaced 1 cycle apart.
- Requests from non-owners while in GRANT are ignored; they are arbitrated in the next IDLE cycle.
- done while IDLE is ignored.
- Grant is never preempted except by timeout, req-drop, or reset.
- MAX_HOLD=1 gives a single-cycle grant with timeout=1 if neither done nor req-drop occurs.
- gnt is always zero or exactly one-hot. gnt_idx is stable for the whole grant.
- hold_cnt never exceeds MAX_HOLD and never wraps.

Test Plan:
1. Reset, then req=1000 held, done pulsed on 3rd grant cycle -> gnt=1000 one cycle after req, busy=1 for 3 cycles, then gnt=0000, timeout=0, last_idx=0.
2. req=1111 held, done pulsed on every grant's 1st cycle -> grants rotate 1000, 0100, 0010, 0001, 1000, each separated by one idle cycle; gnt_idx sequence 00, 01, 10, 11, 00.
3. MAX_HOLD=15, req=0010 held, done never asserted -> gnt=0010 for exactly 15 cycles, then timeout=1 for 1 cycle with gnt=0000, then re-grant 0010 (only requester) the following cycle.
4. Owner 01 drops req mid-grant while req[3]=1 -> gnt=0000 next cycle, then gnt=0001; gnt never shows two bits set.
5. rst_n pulled low asynchronously during a grant to 2 (gnt=0010) -> gnt=0000, busy=0 immediately without a clock edge. After release with req=1111, first grant is 1000.
6. done=1 and hold_cnt==MAX_HOLD in the same cycle -> release with timeout=0. done pulsed while idle -> no state change.

Source files
------------

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The master side drives requests and done; the slave side is the arbiter.
interface rr_arbiter4_if;
  logic [0:3] req;
  logic       done;
  logic [0:3] gnt;
  logic [0:1] gnt_idx;
  logic       busy;
  logic       timeout;

  modport master (output req, done, input gnt, gnt_idx, busy, timeout);
  modport slave  (input req, done, output gnt, gnt_idx, busy, timeout);
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a bounded hold time.
// One owner at a time; the grant ends on done, on the owner dropping its
// request, or when the hold counter reaches MAX_HOLD (flagged by timeout).
// Every output is a flop; the next-cycle values are computed combinationally.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave bus
);
  localparam int             NUM_REQ  = 4;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [1:0]       last_idx, last_nxt;
  logic [1:0]       idx_q, idx_nxt;
  logic [0:3]       gnt_q, gnt_nxt;
  logic             busy_q, busy_nxt;
  logic             to_q, to_nxt;

  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       own_req;
  logic       at_lim;
  logic       rel;

  // Pick the first requester after last_idx in circular order; scanning from
  // the farthest candidate down lets the nearest one overwrite the result.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    cand    = 2'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last_idx + 2'(k);
      if (bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Release conditions for the current owner.
  always_comb begin
    own_req = bus.req[idx_q];
    at_lim  = (hold_cnt == HOLD_LIM);
    rel     = bus.done | ~own_req | at_lim;
  end

  // Next-state logic: arbitration in IDLE, hold/release in GRANT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = hold_cnt;
    last_nxt  = last_idx;
    idx_nxt   = idx_q;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = GRANT;
          cnt_nxt   = CNT_W'(1);
          idx_nxt   = win_idx;
        end else begin
          idx_nxt   = 2'd0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          last_nxt  = idx_q;
          idx_nxt   = 2'd0;
        end else begin
          cnt_nxt   = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = 2'd0;
      end
    endcase
  end

  // Output values for the next cycle: one-hot decode of the owner index, and
  // a timeout flag only when the limit alone forced the release.
  always_comb begin
    busy_nxt = (state_nxt == GRANT);
    gnt_nxt  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      gnt_nxt[i] = busy_nxt && (idx_nxt == 2'(i));
    to_nxt   = (state == GRANT) && at_lim && !bus.done && own_req;
  end

  // State and output registers; reset leaves requester 0 with top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last_idx <= 2'b11;
      idx_q    <= 2'd0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= cnt_nxt;
      last_idx <= last_nxt;
      idx_q    <= idx_nxt;
      gnt_q    <= gnt_nxt;
      busy_q   <= busy_nxt;
      to_q     <= to_nxt;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = to_q;
endmodule
